rgb2gray: RTL

RGB2GRAY -- requirements
Module: rgb2gray

---
 rtl/rgb2gray.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rgb2gray.sv
// rgb2gray: streaming RGB to gray converter with a fixed 3-cycle latency.
//
// A new pixel is accepted every cycle. There is no stall and no backpressure.
// The conversion mode is latched only on a vsync rising edge. Each pixel then
// carries its own mode down the pipeline.
//
// Pipeline stages:
//   S1 registers the inputs together with the latched mode.
//   S2 forms the weighted terms for that mode.
//   S3 sums, rounds and drives the outputs.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   vid_in_active  input pixel valid
//   vid_in_data    packed pixel {R, G, B}, R in the MSBs
//   vid_in_hsync   horizontal sync, passed through
//   vid_in_vsync   vertical sync, passed through; its rising edge marks a frame
//   cfg_mode       requested mode: 0 luma, 1 average, 2 green, 3 max
//   vid_out_active vid_in_active delayed 3 cycles
//   vid_out_data   gray pixel, forced to 0 when vid_out_active is 0
//   vid_out_hsync  vid_in_hsync delayed 3 cycles
//   vid_out_vsync  vid_in_vsync delayed 3 cycles
//   mode_active    mode currently applied to newly accepted pixels
module rgb2gray #(
  parameter int VIDEO_GRAY_DATA_WIDTH = 8,
  parameter int VIDEO_RGB_DATA_WIDTH  = VIDEO_GRAY_DATA_WIDTH * 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vid_in_active,
  input  logic [VIDEO_RGB_DATA_WIDTH-1:0]  vid_in_data,
  input  logic                             vid_in_hsync,
  input  logic                             vid_in_vsync,
  input  logic [1:0]                       cfg_mode,
  output logic                             vid_out_active,
  output logic [VIDEO_GRAY_DATA_WIDTH-1:0] vid_out_data,
  output logic                             vid_out_hsync,
  output logic                             vid_out_vsync,
  output logic [1:0]                       mode_active
);

  localparam int W  = VIDEO_GRAY_DATA_WIDTH;
  // The largest luma sum is 256*(2^W-1)+128, which stays below 2^(W+8).
  localparam int IW = W + 10;

  localparam logic [1:0] MODE_LUMA  = 2'd0;
  localparam logic [1:0] MODE_AVG   = 2'd1;
  localparam logic [1:0] MODE_GREEN = 2'd2;

  localparam logic [IW-1:0] K_R = IW'(77);
  localparam logic [IW-1:0] K_G = IW'(150);
  localparam logic [IW-1:0] K_B = IW'(29);

  logic [1:0]   mode_r;
  logic         vs_d;

  logic         s1_active, s1_hsync, s1_vsync;
  logic [1:0]   s1_mode;
  logic [W-1:0] s1_r, s1_g, s1_b;

  logic          s2_active, s2_hsync, s2_vsync;
  logic [1:0]    s2_mode;
  logic [IW-1:0] s2_t0, s2_t1, s2_t2;

  logic [W-1:0]  max_rg, max_rgb;
  logic [IW-1:0] t0, t1, t2;
  logic [IW-1:0] sum, sum_luma, sum_avg;
  logic [W-1:0]  gray;

  assign mode_active = mode_r;

  // Mode latch. The pixel sampled in the same cycle as the vsync edge still
  // captures the old mode_r into S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= 2'd0;
      vs_d   <= 1'b0;
    end else begin
      vs_d <= vid_in_vsync;
      if (vid_in_vsync && !vs_d) begin
        mode_r <= cfg_mode;
      end
    end
  end

  // S1: capture the inputs and the mode that applies to this pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_mode   <= 2'd0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
    end else begin
      s1_active <= vid_in_active;
      s1_hsync  <= vid_in_hsync;
      s1_vsync  <= vid_in_vsync;
      s1_mode   <= mode_r;
      s1_r      <= vid_in_data[3*W-1:2*W];
      s1_g      <= vid_in_data[2*W-1:W];
      s1_b      <= vid_in_data[W-1:0];
    end
  end

  // Weighted terms. Modes 2 and 3 place their result in t0 only, so that S3
  // can pass t0 straight through.
  always_comb begin
    max_rg  = (s1_r > s1_g) ? s1_r : s1_g;
    max_rgb = (max_rg > s1_b) ? max_rg : s1_b;
    t0 = '0;
    t1 = '0;
    t2 = '0;
    case (s1_mode)
      MODE_LUMA: begin
        t0 = IW'(s1_r) * K_R;
        t1 = IW'(s1_g) * K_G;
        t2 = IW'(s1_b) * K_B;
      end
      MODE_AVG: begin
        t0 = IW'(s1_r);
        t1 = IW'(s1_g) << 1;
        t2 = IW'(s1_b);
      end
      MODE_GREEN: t0 = IW'(s1_g);
      default:    t0 = IW'(max_rgb);
    endcase
  end

  // S2: register the weighted terms.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_active <= 1'b0;
      s2_hsync  <= 1'b0;
      s2_vsync  <= 1'b0;
      s2_mode   <= 2'd0;
      s2_t0     <= '0;
      s2_t1     <= '0;
      s2_t2     <= '0;
    end else begin
      s2_active <= s1_active;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
      s2_mode   <= s1_mode;
      s2_t0     <= t0;
      s2_t1     <= t1;
      s2_t2     <= t2;
    end
  end

  // Sum and round. Both rounded results already fit in W bits.
  always_comb begin
    sum      = s2_t0 + s2_t1 + s2_t2;
    sum_luma = sum + IW'(128);
    sum_avg  = sum + IW'(2);
    case (s2_mode)
      MODE_LUMA: gray = W'(sum_luma >> 8);
      MODE_AVG:  gray = W'(sum_avg >> 2);
      default:   gray = W'(s2_t0);
    endcase
  end

  // S3: drive the outputs. Data is blanked whenever the pixel is not active.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_out_active <= 1'b0;
      vid_out_hsync  <= 1'b0;
      vid_out_vsync  <= 1'b0;
      vid_out_data   <= '0;
    end else begin
      vid_out_active <= s2_active;
      vid_out_hsync  <= s2_hsync;
      vid_out_vsync  <= s2_vsync;
      vid_out_data   <= s2_active ? gray : '0;
    end
  end

endmodule
